// File: rtl/board_win_checker.sv
// board_win_checker: raster-scans an N x N board through a 1-cycle-latency read port and reports a one-colour win.
// Optional macro WIN_COUNT_CELLS_EN: read every cell and report MATCH_COUNT instead of aborting on first mismatch.
module board_win_checker #(
    parameter int MAX_SIZE = 26,
    parameter int IDX_W    = 5,
    parameter int COLOR_W  = 3,
    parameter int CNT_W    = 10
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [IDX_W-1:0]   size_i,
    output logic               rd_en_o,
    output logic [IDX_W-1:0]   rd_row_o,
    output logic [IDX_W-1:0]   rd_col_o,
    input  logic [COLOR_W-1:0] rd_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               won_o,
    output logic [COLOR_W-1:0] ref_color_o,
    output logic [CNT_W-1:0]   match_count_o
);

    // state  | meaning
    // IDLE   | waiting for start_i
    // SCAN   | issuing reads and comparing returned cells
    // FINISH | one-cycle done pulse, results valid
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_SIZE);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic               rd_en_q, rd_en_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic               cmp_first_q, cmp_first_d;
    logic               cmp_last_q, cmp_last_d;
    logic [COLOR_W-1:0] ref_q, ref_d;
    logic               won_q, won_d;
    logic [COLOR_W-1:0] ref_color_q, ref_color_d;

    logic [IDX_W-1:0]   size_clamped;
    logic               last_addr;
    logic               cell_match;
    logic [COLOR_W-1:0] ref_cur;

`ifdef WIN_COUNT_CELLS_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   n_sq;
`endif

    assign size_clamped = (size_i > MAX_N) ? MAX_N : size_i;
    assign last_addr    = (row_q == n_q - IDX_W'(1)) && (col_q == n_q - IDX_W'(1));
    // The first returned cell defines the reference, so it always matches.
    assign cell_match   = cmp_first_q || (rd_data_i == ref_q);
    assign ref_cur      = cmp_first_q ? rd_data_i : ref_q;

`ifdef WIN_COUNT_CELLS_EN
    assign cnt_next = cnt_q + CNT_W'(cell_match);
    assign n_sq     = CNT_W'(n_q) * CNT_W'(n_q);
`endif

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_en_d     = rd_en_q;
        cmp_valid_d = 1'b0;
        cmp_first_d = 1'b0;
        cmp_last_d  = 1'b0;
        ref_d       = ref_q;
        won_d       = won_q;
        ref_color_d = ref_color_q;
`ifdef WIN_COUNT_CELLS_EN
        cnt_d         = cnt_q;
        match_count_d = match_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d   = size_clamped;
                    row_d = '0;
                    col_d = '0;
`ifdef WIN_COUNT_CELLS_EN
                    cnt_d = '0;
`endif
                    if (size_clamped == '0) begin
                        state_d     = FINISH;
                        won_d       = 1'b0;
                        ref_color_d = '0;
`ifdef WIN_COUNT_CELLS_EN
                        match_count_d = '0;
`endif
                    end else begin
                        state_d = SCAN;
                        rd_en_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (rd_en_q) begin
                    cmp_valid_d = 1'b1;
                    cmp_first_d = (row_q == '0) && (col_q == '0);
                    cmp_last_d  = last_addr;
                    if (last_addr) begin
                        rd_en_d = 1'b0;
                    end else if (col_q == n_q - IDX_W'(1)) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
                if (cmp_valid_q) begin
                    ref_d = ref_cur;
`ifdef WIN_COUNT_CELLS_EN
                    cnt_d = cnt_next;
                    if (cmp_last_q) begin
                        state_d       = FINISH;
                        won_d         = (cnt_next == n_sq);
                        ref_color_d   = ref_cur;
                        match_count_d = cnt_next;
                    end
`else
                    if (!cell_match) begin
                        state_d     = FINISH;
                        won_d       = 1'b0;
                        ref_color_d = ref_cur;
                        rd_en_d     = 1'b0;
                        cmp_valid_d = 1'b0;
                    end else if (cmp_last_q) begin
                        state_d     = FINISH;
                        won_d       = 1'b1;
                        ref_color_d = ref_cur;
                    end
`endif
                end
            end
            FINISH: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            n_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rd_en_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_first_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            ref_q       <= '0;
            won_q       <= 1'b0;
            ref_color_q <= '0;
`ifdef WIN_COUNT_CELLS_EN
            cnt_q         <= '0;
            match_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_en_q     <= rd_en_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_first_q <= cmp_first_d;
            cmp_last_q  <= cmp_last_d;
            ref_q       <= ref_d;
            won_q       <= won_d;
            ref_color_q <= ref_color_d;
`ifdef WIN_COUNT_CELLS_EN
            cnt_q         <= cnt_d;
            match_count_q <= match_count_d;
`endif
        end
    end

    assign rd_en_o     = rd_en_q;
    assign rd_row_o    = row_q;
    assign rd_col_o    = col_q;
    assign busy_o      = (state_q == SCAN);
    assign done_o      = (state_q == FINISH);
    assign won_o       = won_q;
    assign ref_color_o = ref_color_q;
`ifdef WIN_COUNT_CELLS_EN
    assign match_count_o = match_count_q;
`else
    assign match_count_o = '0;
`endif

endmodule
